// File: rtl/bht_npc_unit_pkg.sv
// Shared definitions for the next-PC unit: 2-bit counter encodings,
// next-PC source select codes and the saturating counter update helper.
package bht_npc_unit_pkg;

   localparam logic [1:0] CTR_SNT = 2'd0;   // strongly not taken
   localparam logic [1:0] CTR_WNT = 2'd1;   // weakly not taken
   localparam logic [1:0] CTR_WT  = 2'd2;   // weakly taken
   localparam logic [1:0] CTR_ST  = 2'd3;   // strongly taken

   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_PRED = 3'd1,
      SEL_JAL  = 3'd2,
      SEL_JALR = 3'd3,
      SEL_FIX  = 3'd4
   } npc_sel_e;

   // Saturating 2-bit counter step toward the observed outcome.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
         default: nxt = CTR_WNT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bht_npc_unit_table.sv
// Direct-mapped branch history/target table: combinational read port for
// the fetch PC, one write port for the EX branch, counter saturation.
// Reads return the contents present before the clock edge (no bypass).
module bht_npc_unit_table
   import bht_npc_unit_pkg::*;
#(
   parameter int         IDX_W     = 5,
   parameter logic [1:0] ALLOC_CTR = 2'b10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    rd_idx,
   input  logic [29-IDX_W:0]   rd_tag,
   output logic                pred_taken,
   output logic [31:0]         pred_target,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [29-IDX_W:0]   wr_tag,
   input  logic                wr_taken,
   input  logic [31:0]         wr_target
);

   localparam int ENTRIES = 2 ** IDX_W;
   localparam int TAG_W   = 30 - IDX_W;

   logic             valid_r  [ENTRIES];
   logic [TAG_W-1:0] tag_r    [ENTRIES];
   logic [31:0]      target_r [ENTRIES];
   logic [1:0]       ctr_r    [ENTRIES];

   logic rd_hit_s;
   logic wr_hit_s;

   // Fetch-side lookup and EX-side hit detection.
   always_comb begin
      rd_hit_s    = valid_r[rd_idx] && (tag_r[rd_idx] == rd_tag);
      wr_hit_s    = valid_r[wr_idx] && (tag_r[wr_idx] == wr_tag);
      pred_taken  = rd_hit_s & ctr_r[rd_idx][1];
      pred_target = target_r[rd_idx];
   end

   // Table storage: reset invalidates everything, otherwise train on EX branches.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= {TAG_W{1'b0}};
            target_r[i] <= 32'h0000_0000;
            ctr_r[i]    <= CTR_WNT;
         end
      end else if (wr_en) begin
         if (wr_hit_s) begin
            ctr_r[wr_idx] <= ctr_next(ctr_r[wr_idx], wr_taken);
            if (wr_taken) begin
               target_r[wr_idx] <= wr_target;
            end
         end else if (wr_taken) begin
            // Allocate or replace the aliasing entry; untaken misses leave it alone.
            valid_r[wr_idx]  <= 1'b1;
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
            ctr_r[wr_idx]    <= ALLOC_CTR;
         end
      end
   end

endmodule

// File: rtl/bht_npc_unit.sv
// Next-PC unit with integrated BHT/BTB: misprediction detection, next-PC
// priority mux and optional branch statistics.
// Optional feature macro: BPU_STATS_EN (adds BrCnt/MissCnt counters;
// when undefined both outputs are tied to zero).
module bht_npc_unit
   import bht_npc_unit_pkg::*;
#(
   parameter int         IDX_W     = 5,
   parameter logic [1:0] ALLOC_CTR = 2'b10,
   parameter int         CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      PCF,
   input  logic             JalD,
   input  logic [31:0]      JalTarget,
   input  logic             JalrE,
   input  logic [31:0]      JalrTarget,
   input  logic             BranchE,
   input  logic             BranchTakenE,
   input  logic [31:0]      BranchTargetE,
   input  logic [31:0]      PCE,
   input  logic             PredTakenE,
   output logic [31:0]      PC_In,
   output logic             PredTakenF,
   output logic             MissE,
   output logic [CNT_W-1:0] BrCnt,
   output logic [CNT_W-1:0] MissCnt
);

   logic [31:0] pre_pc_s;
   logic [31:0] fix_pc_s;
   logic        pred_s;
   npc_sel_e    sel_s;

   bht_npc_unit_table #(
      .IDX_W     (IDX_W),
      .ALLOC_CTR (ALLOC_CTR)
   ) u_table (
      .clk         (clk),
      .rst         (rst),
      .rd_idx      (PCF[IDX_W+1:2]),
      .rd_tag      (PCF[31:IDX_W+2]),
      .pred_taken  (pred_s),
      .pred_target (pre_pc_s),
      .wr_en       (BranchE),
      .wr_idx      (PCE[IDX_W+1:2]),
      .wr_tag      (PCE[31:IDX_W+2]),
      .wr_taken    (BranchTakenE),
      .wr_target   (BranchTargetE)
   );

   // Misprediction check and the PC that repairs it.
   always_comb begin
      MissE = BranchE & (BranchTakenE != PredTakenE);
      if (BranchTakenE) begin
         fix_pc_s = BranchTargetE;
      end else begin
         fix_pc_s = PCE + 32'd4;
      end
   end

   // Next-PC source priority: repair, JALR, JAL, prediction, sequential.
   always_comb begin
      PredTakenF = pred_s;
      if (MissE) begin
         sel_s = SEL_FIX;
      end else if (JalrE) begin
         sel_s = SEL_JALR;
      end else if (JalD) begin
         sel_s = SEL_JAL;
      end else if (pred_s) begin
         sel_s = SEL_PRED;
      end else begin
         sel_s = SEL_SEQ;
      end
      case (sel_s)
         SEL_FIX:  PC_In = fix_pc_s;
         SEL_JALR: PC_In = JalrTarget;
         SEL_JAL:  PC_In = JalTarget;
         SEL_PRED: PC_In = pre_pc_s;
         SEL_SEQ:  PC_In = PCF + 32'd4;
         default:  PC_In = PCF + 32'd4;
      endcase
   end

`ifdef BPU_STATS_EN
   logic [CNT_W-1:0] br_cnt_r;
   logic [CNT_W-1:0] miss_cnt_r;

   // Retired-branch and misprediction counters, wrapping naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt_r   <= {CNT_W{1'b0}};
         miss_cnt_r <= {CNT_W{1'b0}};
      end else begin
         br_cnt_r   <= br_cnt_r + {{(CNT_W-1){1'b0}}, BranchE};
         miss_cnt_r <= miss_cnt_r + {{(CNT_W-1){1'b0}}, MissE};
      end
   end

   assign BrCnt   = br_cnt_r;
   assign MissCnt = miss_cnt_r;
`else
   assign BrCnt   = {CNT_W{1'b0}};
   assign MissCnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_bht_npc_unit.sv
// Directed self-checking bench for bht_npc_unit (default parameters,
// 32-entry table). Statistics expectations follow BPU_STATS_EN.
module tb_bht_npc_unit;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic        JalD;
   logic [31:0] JalTarget;
   logic        JalrE;
   logic [31:0] JalrTarget;
   logic        BranchE;
   logic        BranchTakenE;
   logic [31:0] BranchTargetE;
   logic [31:0] PCE;
   logic        PredTakenE;
   logic [31:0] PC_In;
   logic        PredTakenF;
   logic        MissE;
   logic [31:0] BrCnt;
   logic [31:0] MissCnt;

   int checks = 0;
   int errors = 0;

`ifdef BPU_STATS_EN
   localparam logic [31:0] EXP_BR   = 32'd10;
   localparam logic [31:0] EXP_MISS = 32'd3;
`else
   localparam logic [31:0] EXP_BR   = 32'd0;
   localparam logic [31:0] EXP_MISS = 32'd0;
`endif

   bht_npc_unit dut (
      .clk           (clk),
      .rst           (rst),
      .PCF           (PCF),
      .JalD          (JalD),
      .JalTarget     (JalTarget),
      .JalrE         (JalrE),
      .JalrTarget    (JalrTarget),
      .BranchE       (BranchE),
      .BranchTakenE  (BranchTakenE),
      .BranchTargetE (BranchTargetE),
      .PCE           (PCE),
      .PredTakenE    (PredTakenE),
      .PC_In         (PC_In),
      .PredTakenF    (PredTakenF),
      .MissE         (MissE),
      .BrCnt         (BrCnt),
      .MissCnt       (MissCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      JalD = 1'b0; JalTarget = 32'h0; JalrE = 1'b0; JalrTarget = 32'h0;
      BranchE = 1'b0; BranchTakenE = 1'b0; BranchTargetE = 32'h0;
      PCE = 32'h0; PredTakenE = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic branch(input logic [31:0] pc, input logic taken,
                         input logic [31:0] tgt, input logic pred);
      BranchE = 1'b1; PCE = pc; BranchTakenE = taken;
      BranchTargetE = tgt; PredTakenE = pred;
   endtask

   task automatic test_reset();
      idle(); rst = 1'b1; PCF = 32'h100;
      tick(); tick();
      rst = 1'b0; #1;
      checks++; if (PC_In !== 32'h104) begin errors++; $display("FAIL reset_pc_in: got %h expected %h", PC_In, 32'h104); end
      checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", PredTakenF); end
      checks++; if (MissE !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b expected 0", MissE); end
      checks++; if (BrCnt !== 32'd0 || MissCnt !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", BrCnt, MissCnt); end
   endtask

   task automatic test_taken_alloc();
      branch(32'h200, 1'b1, 32'h300, 1'b0); #1;
      checks++; if (MissE !== 1'b1) begin errors++; $display("FAIL alloc_miss: got %b expected 1", MissE); end
      checks++; if (PC_In !== 32'h300) begin errors++; $display("FAIL alloc_fix: got %h expected %h", PC_In, 32'h300); end
      tick(); idle(); PCF = 32'h200; #1;
      checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %b expected 1", PredTakenF); end
      checks++; if (PC_In !== 32'h300) begin errors++; $display("FAIL alloc_target: got %h expected %h", PC_In, 32'h300); end
   endtask

   task automatic test_not_taken_sat();
      PCF = 32'h100;
      branch(32'h200, 1'b0, 32'h300, 1'b1); #1;
      checks++; if (MissE !== 1'b1) begin errors++; $display("FAIL nt_miss: got %b expected 1", MissE); end
      checks++; if (PC_In !== 32'h204) begin errors++; $display("FAIL nt_fix: got %h expected %h", PC_In, 32'h204); end
      tick(); idle(); PCF = 32'h200; #1;
      checks++; if (PredTakenF !== 1'b0 || PC_In !== 32'h204) begin errors++; $display("FAIL nt_pred: got %b/%h expected 0/%h", PredTakenF, PC_In, 32'h204); end
      // two more not-taken: ctr 1 -> 0 -> 0
      for (int i = 0; i < 2; i++) begin
         branch(32'h200, 1'b0, 32'h300, 1'b0); #1;
         checks++; if (MissE !== 1'b0) begin errors++; $display("FAIL nt_correct_%0d: got %b expected 0", i, MissE); end
         tick();
      end
      // one taken from a saturated 0 gives 1, still predicting not taken;
      // lookup in the same cycle sees the pre-edge contents
      PCF = 32'h200;
      branch(32'h200, 1'b1, 32'h340, 1'b0); #1;
      checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL same_cycle_pred: got %b expected 0", PredTakenF); end
      tick(); idle(); #1;
      checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL sat_low: got %b expected 0", PredTakenF); end
      branch(32'h200, 1'b1, 32'h340, 1'b0); tick(); idle(); #1;
      checks++; if (PredTakenF !== 1'b1 || PC_In !== 32'h340) begin errors++; $display("FAIL retarget: got %b/%h expected 1/%h", PredTakenF, PC_In, 32'h340); end
   endtask

   task automatic test_alias();
      PCF = 32'h280; #1;
      checks++; if (PredTakenF !== 1'b0 || PC_In !== 32'h284) begin errors++; $display("FAIL alias_lookup: got %b/%h expected 0/%h", PredTakenF, PC_In, 32'h284); end
      branch(32'h280, 1'b1, 32'h500, 1'b0); tick(); idle();
      PCF = 32'h200; #1;
      checks++; if (PredTakenF !== 1'b0 || PC_In !== 32'h204) begin errors++; $display("FAIL alias_evicted: got %b/%h expected 0/%h", PredTakenF, PC_In, 32'h204); end
      // untaken miss on a third alias must not disturb the entry
      branch(32'h600, 1'b0, 32'h700, 1'b0); tick(); idle();
      PCF = 32'h280; #1;
      checks++; if (PredTakenF !== 1'b1 || PC_In !== 32'h500) begin errors++; $display("FAIL alias_new: got %b/%h expected 1/%h", PredTakenF, PC_In, 32'h500); end
   endtask

   task automatic test_priority();
      PCF = 32'h280; JalD = 1'b1; JalTarget = 32'h700;
      branch(32'h900, 1'b0, 32'hA00, 1'b1); #1;
      checks++; if (PC_In !== 32'h904) begin errors++; $display("FAIL prio_fix: got %h expected %h", PC_In, 32'h904); end
      BranchE = 1'b0; JalrE = 1'b1; JalrTarget = 32'h800; #1;
      checks++; if (PC_In !== 32'h800) begin errors++; $display("FAIL prio_jalr: got %h expected %h", PC_In, 32'h800); end
      JalrE = 1'b0; #1;
      checks++; if (PC_In !== 32'h700) begin errors++; $display("FAIL prio_jal: got %h expected %h", PC_In, 32'h700); end
      JalD = 1'b0; #1;
      checks++; if (PC_In !== 32'h500) begin errors++; $display("FAIL prio_pred: got %h expected %h", PC_In, 32'h500); end
      idle(); tick();
   endtask

   task automatic test_stats();
      // reset during a taken branch: table cleared, update dropped
      rst = 1'b1; PCF = 32'h280;
      branch(32'h280, 1'b1, 32'h500, 1'b1);
      tick(); rst = 1'b0; idle(); #1;
      checks++; if (PredTakenF !== 1'b0 || PC_In !== 32'h284) begin errors++; $display("FAIL mid_reset: got %b/%h expected 0/%h", PredTakenF, PC_In, 32'h284); end
      for (int i = 0; i < 10; i++) begin
         case (i)
            0:       branch(32'h400, 1'b1, 32'h480, 1'b0);
            8:       branch(32'h400, 1'b0, 32'h480, 1'b1);
            9:       branch(32'h400, 1'b1, 32'h480, 1'b0);
            default: branch(32'h400, 1'b1, 32'h480, 1'b1);
         endcase
         tick();
      end
      idle(); tick();
      checks++; if (BrCnt !== EXP_BR) begin errors++; $display("FAIL br_cnt: got %0d expected %0d", BrCnt, EXP_BR); end
      checks++; if (MissCnt !== EXP_MISS) begin errors++; $display("FAIL miss_cnt: got %0d expected %0d", MissCnt, EXP_MISS); end
   endtask

   initial begin
      test_reset();
      test_taken_alloc();
      test_not_taken_sat();
      test_alias();
      test_priority();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
